// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I sequencing controller: states,
// datapath select codes, opcodes, ALU operations and the per-state control word.
package multicycle_control_fsm_pkg;

  localparam int FUNCT3_LEN          = 3;
  localparam int ALU_CNTL_BITS_COUNT = 4;

  typedef enum logic [3:0] {
    STATE_IDLE, STATE_FETCH, STATE_DECODE, STATE_MEMADR, STATE_MEMREAD,
    STATE_MEMWB, STATE_MEMWRITE, STATE_EXECR, STATE_EXECI, STATE_LUI,
    STATE_ALUWB, STATE_BRANCH, STATE_JALR, STATE_JAL, STATE_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_OTH} alu_op_t;

  localparam logic [1:0] SRC_A_PC      = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC   = 2'b01;
  localparam logic [1:0] SRC_A_RS1     = 2'b10;
  localparam logic [1:0] SRC_A_ZERO    = 2'b11;
  localparam logic [1:0] SRC_B_RS2     = 2'b00;
  localparam logic [1:0] SRC_B_IMM     = 2'b01;
  localparam logic [1:0] SRC_B_FOUR    = 2'b10;
  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_MEMDR  = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // fetch/branch/store mark the states whose enables are gated by mem_ready or zero
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       fetch;
    logic       branch;
    logic       store;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    alu_op_t    alu_op;
    logic       done;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      STATE_FETCH: begin
        c.mem_req = 1'b1; c.fetch = 1'b1;
        c.src_a = SRC_A_PC; c.src_b = SRC_B_FOUR; c.result_src = RESULT_ALU;
      end
      STATE_DECODE:  begin c.src_a = SRC_A_OLDPC; c.src_b = SRC_B_IMM; end
      STATE_MEMADR:  begin c.src_a = SRC_A_RS1;   c.src_b = SRC_B_IMM; end
      STATE_MEMREAD: begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      STATE_MEMWB: begin
        c.result_src = RESULT_MEMDR; c.reg_write = 1'b1; c.done = 1'b1;
      end
      STATE_MEMWRITE: begin
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; c.store = 1'b1;
      end
      STATE_EXECR: begin c.src_a = SRC_A_RS1;  c.src_b = SRC_B_RS2; c.alu_op = ALU_OP_OTH; end
      STATE_EXECI: begin c.src_a = SRC_A_RS1;  c.src_b = SRC_B_IMM; c.alu_op = ALU_OP_OTH; end
      STATE_LUI:   begin c.src_a = SRC_A_ZERO; c.src_b = SRC_B_IMM; end
      STATE_ALUWB: begin
        c.result_src = RESULT_ALUOUT; c.reg_write = 1'b1; c.done = 1'b1;
      end
      STATE_BRANCH: begin
        c.src_a = SRC_A_RS1; c.src_b = SRC_B_RS2; c.alu_op = ALU_OP_SUB;
        c.result_src = RESULT_ALUOUT; c.branch = 1'b1; c.done = 1'b1;
      end
      STATE_JALR: begin c.src_a = SRC_A_RS1; c.src_b = SRC_B_IMM; end
      STATE_JAL: begin
        c.src_a = SRC_A_OLDPC; c.src_b = SRC_B_FOUR;
        c.result_src = RESULT_ALUOUT; c.pc_write = 1'b1;
      end
      STATE_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Instruction fields, flags and control outputs between the controller (master)
// and the datapath/memory side (slave).
interface multicycle_control_fsm_if
  import multicycle_control_fsm_pkg::*;
  ;
  logic [6:0]                     opcode;
  logic [FUNCT3_LEN-1:0]          funct3;
  logic                           funct7_bit5;
  logic                           zero;
  logic                           mem_ready;
  logic                           mem_req;
  logic                           mem_write;
  logic                           adr_src;
  logic                           ir_write;
  logic                           pc_write;
  logic                           reg_write;
  logic [1:0]                     alu_src_a;
  logic [1:0]                     alu_src_b;
  logic [1:0]                     result_src;
  logic [ALU_CNTL_BITS_COUNT-1:0] alu_control;
  logic                           instr_done;
  logic                           illegal;

  modport master (
    input  opcode, funct3, funct7_bit5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, instr_done, illegal
  );

  modport slave (
    output opcode, funct3, funct7_bit5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_control_fsm_alu_dec.sv
// ALU decoder: maps the controller's ALU operation plus instruction fields to
// the ALU control code.
module multicycle_control_fsm_alu_dec
  import multicycle_control_fsm_pkg::*;
(
  input  alu_op_t                        i_alu_op,
  input  logic [FUNCT3_LEN-1:0]          i_funct3,
  input  logic                           i_funct7_bit5,
  input  logic                           i_op5,
  output logic [ALU_CNTL_BITS_COUNT-1:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALU_OP_SUB: o_alu_control = ALU_SUB;
      ALU_OP_OTH: begin
        case (i_funct3)
          // funct7 bit 5 selects SUB only for register-register ops; addi ignores it
          3'b000:  o_alu_control = (i_op5 && i_funct7_bit5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_control = ALU_SLL;
          3'b010:  o_alu_control = ALU_SLT;
          3'b011:  o_alu_control = ALU_SLTU;
          3'b100:  o_alu_control = ALU_XOR;
          3'b101:  o_alu_control = i_funct7_bit5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_control = ALU_OR;
          default: o_alu_control = ALU_AND;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing FSM: registered per-state control word, with
// fetch/branch/store enables gated by mem_ready or zero.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;

  always_comb begin
    w_next = r_state;
    case (r_state)
      STATE_IDLE:     w_next = STATE_FETCH;
      STATE_FETCH:    if (bus.mem_ready) w_next = STATE_DECODE;
      STATE_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: w_next = STATE_MEMADR;
          OP_RTYPE:          w_next = STATE_EXECR;
          OP_ITYPE:          w_next = STATE_EXECI;
          OP_BRANCH:         w_next = STATE_BRANCH;
          OP_JAL:            w_next = STATE_JAL;
          OP_JALR:           w_next = STATE_JALR;
          OP_LUI:            w_next = STATE_LUI;
          default:           w_next = STATE_ILLEGAL;
        endcase
      end
      STATE_MEMADR:   w_next = bus.opcode[5] ? STATE_MEMWRITE : STATE_MEMREAD;
      STATE_MEMREAD:  if (bus.mem_ready) w_next = STATE_MEMWB;
      STATE_MEMWB:    w_next = STATE_FETCH;
      STATE_MEMWRITE: if (bus.mem_ready) w_next = STATE_FETCH;
      STATE_EXECR, STATE_EXECI, STATE_LUI: w_next = STATE_ALUWB;
      STATE_ALUWB:    w_next = STATE_FETCH;
      STATE_BRANCH:   w_next = STATE_FETCH;
      STATE_JALR:     w_next = STATE_JAL;
      STATE_JAL:      w_next = STATE_ALUWB;
      STATE_ILLEGAL:  w_next = STATE_ILLEGAL;
      default:        w_next = STATE_IDLE;
    endcase
  end

  // control word is registered alongside the state so reset clears every enable at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STATE_IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next);
    end
  end

  assign bus.mem_req    = r_ctrl.mem_req;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.adr_src    = r_ctrl.adr_src;
  assign bus.ir_write   = r_ctrl.fetch & bus.mem_ready;
  assign bus.pc_write   = r_ctrl.pc_write
                        | (r_ctrl.fetch & bus.mem_ready)
                        | (r_ctrl.branch & (bus.zero ^ bus.funct3[0]));
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.alu_src_a  = r_ctrl.src_a;
  assign bus.alu_src_b  = r_ctrl.src_b;
  assign bus.result_src = r_ctrl.result_src;
  assign bus.instr_done = r_ctrl.done | (r_ctrl.store & bus.mem_ready);
  assign bus.illegal    = r_ctrl.illegal;

  multicycle_control_fsm_alu_dec u_alu_dec (
    .i_alu_op      (r_ctrl.alu_op),
    .i_funct3      (bus.funct3),
    .i_funct7_bit5 (bus.funct7_bit5),
    .i_op5         (bus.opcode[5]),
    .o_alu_control (bus.alu_control)
  );

endmodule
